// File: rtl/stream_write_ctrl_pkg.sv
// Shared definitions for the stream-to-ring write controller: FSM state
// encodings and the beat-count to byte-length helper.
package stream_write_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_REQ  = 3'd2,
    S_ACK  = 3'd3,
    S_RUN  = 3'd4
  } state_t;

  function automatic logic [31:0] beats_to_bytes(input logic [31:0] beats,
                                                 input int unsigned d_power);
    return beats << d_power;
  endfunction

endpackage

// File: rtl/stream_write_ctrl_if.sv
// Stream input, write-master request/data channel and status of stream_write_ctrl.
// master = controller side, slave = stream source / write master side.
interface stream_write_ctrl_if #(
  parameter int D_WIDTH = 64
);
  logic [31:0]        i_base_addr;
  logic [31:0]        i_buf_len;
  logic               i_start;
  logic               i_stop;
  logic [D_WIDTH-1:0] i_s_data;
  logic               i_s_valid;
  logic               o_s_ready;
  logic [31:0]        o_addr;
  logic [31:0]        o_len;
  logic               o_req;
  logic               i_busy;
  logic [D_WIDTH-1:0] o_data;
  logic               o_valid;
  logic               i_ready;
  logic               o_running;
  logic [15:0]        o_wrap_cnt;

  modport master (
    input  i_base_addr, i_buf_len, i_start, i_stop, i_s_data, i_s_valid,
           i_busy, i_ready,
    output o_s_ready, o_addr, o_len, o_req, o_data, o_valid, o_running,
           o_wrap_cnt
  );

  modport slave (
    output i_base_addr, i_buf_len, i_start, i_stop, i_s_data, i_s_valid,
           i_busy, i_ready,
    input  o_s_ready, o_addr, o_len, o_req, o_data, o_valid, o_running,
           o_wrap_cnt
  );
endinterface

// File: rtl/stream_write_ctrl_fifo.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO with level output.
// A push into a full FIFO is ignored, so stored data is never overwritten.
module sync_fifo_fwft #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/stream_write_ctrl.sv
// Buffers a beat stream and issues fixed-size chunk writes into a ring buffer.
// Optional macro STREAM_WR_DROP_EN: drop beats at a full FIFO and count them.
//
// state  | meaning
// S_IDLE | stopped, stream input blocked
// S_FILL | waiting for a full chunk in the FIFO and an idle master
// S_REQ  | one-cycle request pulse with address/length
// S_ACK  | waiting for the master to go busy, beats may flow
// S_RUN  | streaming the chunk until all beats popped and master idle
module stream_write_ctrl
  import stream_write_ctrl_pkg::*;
#(
  parameter int D_POWER    = 3,
  parameter int CHUNK_LOG2 = 4,
  parameter int FIFO_LOG2  = CHUNK_LOG2 + 1
) (
  input  logic                sys_clock,
  input  logic                async_reset,
  stream_write_ctrl_if.master bus
`ifdef STREAM_WR_DROP_EN
  ,
  output logic [31:0]         o_drop_cnt
`endif
);
  localparam int D_WIDTH = 8 << D_POWER;
  localparam int CHUNK_W = 1 << CHUNK_LOG2;
  localparam logic [31:0]         CHUNK_BYTES = beats_to_bytes(32'(CHUNK_W), D_POWER);
  localparam logic [FIFO_LOG2:0]  CHUNK_LEVEL = (FIFO_LOG2 + 1)'(CHUNK_W);
  localparam logic [CHUNK_LOG2:0] CHUNK_POP   = {1'b1, {CHUNK_LOG2{1'b0}}};

  state_t              state_q, state_nx;
  logic [31:0]         base_q, len_q, offset_q, next_offset;
  logic [31:0]         addr_q, req_len_q;
  logic [15:0]         wrap_q;
  logic [CHUNK_LOG2:0] popped_q;
  logic                stop_pend_q;
  logic                running, chunk_done, valid, pop, push, s_ready, fifo_flush;
  logic                fifo_full, fifo_empty;
  logic [FIFO_LOG2:0]  fifo_level;
  logic [D_WIDTH-1:0]  fifo_dout;

  assign running     = (state_q != S_IDLE);
  assign chunk_done  = (popped_q == CHUNK_POP);
  assign valid       = !fifo_empty && (state_q == S_ACK || state_q == S_RUN) &&
                       (popped_q < CHUNK_POP);
  assign pop         = valid & bus.i_ready;
  assign fifo_flush  = (state_q == S_IDLE) && bus.i_start;
  assign next_offset = offset_q + CHUNK_BYTES;

  assign bus.o_req      = (state_q == S_REQ);
  assign bus.o_addr     = addr_q;
  assign bus.o_len      = req_len_q;
  assign bus.o_valid    = valid;
  assign bus.o_data     = fifo_dout;
  assign bus.o_running  = running;
  assign bus.o_wrap_cnt = wrap_q;
  assign bus.o_s_ready  = s_ready;

`ifdef STREAM_WR_DROP_EN
  logic drop_evt;
  assign s_ready  = running;
  assign push     = bus.i_s_valid & running & ~fifo_full;
  assign drop_evt = bus.i_s_valid & running & fifo_full;

  always_ff @(posedge sys_clock or negedge async_reset) begin
    if (!async_reset)                     o_drop_cnt <= '0;
    else if (drop_evt && o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 1'b1;
  end
`else
  assign s_ready = running & ~fifo_full;
  assign push    = bus.i_s_valid & s_ready;
`endif

  sync_fifo_fwft #(
    .WIDTH      (D_WIDTH),
    .DEPTH_LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk   (sys_clock),
    .rst_n (async_reset),
    .flush (fifo_flush),
    .push  (push),
    .din   (bus.i_s_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE: if (bus.i_start) state_nx = S_FILL;
      S_FILL: begin
        if (bus.i_stop)                                      state_nx = S_IDLE;
        else if (fifo_level >= CHUNK_LEVEL && !bus.i_busy)   state_nx = S_REQ;
      end
      S_REQ:  state_nx = S_ACK;
      S_ACK:  if (bus.i_busy) state_nx = S_RUN;
      // a stop arriving on the last cycle still counts as pending
      S_RUN: begin
        if (!bus.i_busy && chunk_done)
          state_nx = (stop_pend_q || bus.i_stop) ? S_IDLE : S_FILL;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or negedge async_reset) begin
    if (!async_reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      offset_q    <= '0;
      addr_q      <= '0;
      req_len_q   <= '0;
      wrap_q      <= '0;
      popped_q    <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (state_q == S_IDLE && bus.i_start) begin
        base_q   <= bus.i_base_addr;
        len_q    <= bus.i_buf_len;
        offset_q <= '0;
      end
      if (state_q == S_FILL && state_nx == S_REQ) begin
        addr_q    <= base_q + offset_q;
        req_len_q <= CHUNK_BYTES;
        popped_q  <= '0;
      end else if (pop) begin
        popped_q <= popped_q + 1'b1;
      end
      if (state_q == S_RUN && state_nx != S_RUN) begin
        if (next_offset == len_q) begin
          offset_q <= '0;
          wrap_q   <= wrap_q + 1'b1;
        end else begin
          offset_q <= next_offset;
        end
      end
      if (state_nx == S_IDLE)
        stop_pend_q <= 1'b0;
      else if (bus.i_stop && (state_q == S_REQ || state_q == S_ACK || state_q == S_RUN))
        stop_pend_q <= 1'b1;
    end
  end
endmodule

// File: doc/stream_write_ctrl.md
STREAM_WRITE_CTRL -- requirements
Module: stream_write_ctrl

Interface
REQ-001 SHALL have parameter D_POWER, default 3, log2 bytes per beat (D_WIDTH = 8<<D_POWER).
REQ-002 SHALL have parameter CHUNK_LOG2, default 4, log2 beats per write request (CHUNK_W = 1<<CHUNK_LOG2).
REQ-003 SHALL have parameter FIFO_LOG2, default CHUNK_LOG2+1, log2 FIFO depth in beats.
REQ-004 SHALL have ports, one per line:
 sys_clock  in  1  single clock, rising edge.
 async_reset  in  1  reset, asynchronous, active-low.
 i_base_addr  in  32  ring base, byte address, 4 KiB aligned.
 i_buf_len  in  32  ring length in bytes, nonzero multiple of CHUNK_W<<D_POWER.
 i_start  in  1  start pulse.
 i_stop  in  1  stop pulse.
 i_s_data  in  D_WIDTH  stream beat.
 i_s_valid  in  1  stream beat valid.
 o_s_ready  out  1  stream beat accepted.
 o_addr  out  32  request address to write master.
 o_len  out  32  request length in bytes to write master.
 o_req  out  1  request pulse to write master.
 i_busy  in  1  write master busy.
 o_data  out  D_WIDTH  beat to write master.
 o_valid  out  1  beat valid to write master.
 i_ready  in  1  write master accepts beat.
 o_running  out  1  controller active.
 o_wrap_cnt  out  16  ring wrap count, wraps at 0xFFFF.

Function
REQ-005 Reset SHALL set: o_s_ready 0, o_req 0, o_valid 0, o_addr 0, o_len 0, o_running 0, o_wrap_cnt 0, FIFO empty, state S_IDLE.
REQ-006 States SHALL be S_IDLE, S_FILL, S_REQ, S_ACK, S_RUN.
REQ-007 S_IDLE: i_start -> latch i_base_addr/i_buf_len, offset 0, o_running 1, flush FIFO, S_FILL; otherwise o_running 0.
REQ-008 S_FILL: FIFO level >= CHUNK_W and i_busy 0 -> S_REQ; i_stop -> S_IDLE (stop wins over fill in the same cycle).
REQ-009 S_REQ: o_req 1 for exactly one cycle, o_addr = base+offset, o_len = CHUNK_W<<D_POWER; next S_ACK.
REQ-010 S_ACK: wait for i_busy 1 -> S_RUN; beats may already be popped.
REQ-011 S_RUN: i_busy 0 and CHUNK_W beats popped -> advance offset, S_FILL (or S_IDLE if stop pending).
REQ-012 Offset advance: offset + chunk bytes == latched i_buf_len -> offset 0, o_wrap_cnt +1; else offset + chunk bytes.
REQ-013 o_valid SHALL be FIFO non-empty AND state in {S_ACK,S_RUN} AND popped count < CHUNK_W; pop on o_valid & i_ready; o_data SHALL be FIFO head (first-word-fall-through, zero latency).
REQ-014 Popped counter SHALL be CHUNK_LOG2+1 bits, cleared on entering S_REQ.
REQ-015 i_stop outside S_IDLE/S_FILL SHALL be latched as pending and honoured at chunk end; no partial chunk is ever issued.
REQ-016 Simultaneous push and pop SHALL leave level unchanged; full FIFO SHALL never be overwritten.
REQ-017 i_start outside S_IDLE SHALL be ignored.

Reset
REQ-018 Asserting async_reset mid-chunk SHALL abort immediately to REQ-005 values; FIFO contents are discarded.
REQ-019 Stream push SHALL be inhibited in S_IDLE.

Configuration
REQ-020 Macro STREAM_WR_DROP_EN: defined -> o_s_ready is 1 whenever o_running, beats arriving at full FIFO are discarded and counted on extra output o_drop_cnt (32 bits, reset 0, saturating); undefined -> o_s_ready = o_running AND FIFO not full (lossless backpressure), no o_drop_cnt port.

Structure
REQ-021 Shared package SHALL hold state encodings and the byte-length helper (beats << D_POWER).
REQ-022 FIFO SHALL be sub-module sync_fifo_fwft (depth 1<<FIFO_LOG2, level output, single clock, same reset).

Verification (D_POWER=3, CHUNK_LOG2=4, base 0x1000_0000, buf_len 512)
REQ-023 Start, 16 stream beats, model master -> one o_req, o_addr 0x1000_0000, o_len 128, 16 beats in order.
REQ-024 Stream 80 beats continuously -> addresses 0x..000, 080, 100, 180, 000; o_wrap_cnt = 1 after 4th chunk.
REQ-025 15 beats then i_stop -> no o_req, return S_IDLE, o_running 0.
REQ-026 Master holds i_ready low 50 cycles with stream driving -> FIFO fills to 32, o_s_ready 0 (drop build: o_drop_cnt counts excess), no data loss/reorder.
REQ-027 async_reset asserted during beat 7 of a chunk -> all outputs at reset values next edge; fresh i_start restarts at offset 0.
REQ-028 i_stop during S_RUN -> current chunk completes all 16 beats, then S_IDLE.
